// File: rtl/pkt_arb_if.sv
// Packet stream bundle: one beat per cycle, no backpressure.
// master drives the beat, slave observes it.
interface pkt_arb_if #(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
);
  logic [DATA_W-1:0]  data;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;
  logic               valid;

  modport master (
    output data, sop, eop, empty, valid
  );
  modport slave (
    input data, sop, eop, empty, valid
  );
endinterface

// File: rtl/pkt_arb.sv
// Two-input packet arbiter: round-robin on sop ties, whole-packet
// ownership, colliding packets dropped, saturating statistics.
module pkt_arb #(
  parameter int CNT_W   = 16,
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [1:0]       en,
  input  logic             clr_cnt,
  pkt_arb_if.slave         in0,
  pkt_arb_if.slave         in1,
  pkt_arb_if.master        out,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] drop_cnt0,
  output logic [CNT_W-1:0] drop_cnt1,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  typedef struct packed {
    logic               valid;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [DATA_W-1:0]  data;
  } beat_t;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [1:0]       grant_q, grant_d;
  beat_t            beat_q, beat_d;
  logic [CNT_W-1:0] drop0_q, drop0_d;
  logic [CNT_W-1:0] drop1_q, drop1_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic sop0, sop1, eop0, eop1;
  logic req0, req1, idle, tie;
  logic win0, win1, sel0, sel1;
  logic pkt_inc, err_inc, drop0_inc, drop1_inc;

  assign sop0 = in0.valid & in0.sop;
  assign sop1 = in1.valid & in1.sop;
  assign eop0 = in0.valid & in0.eop;
  assign eop1 = in1.valid & in1.eop;
  assign req0 = sop0 & en[0];
  assign req1 = sop1 & en[1];
  assign idle = (state_q == IDLE);
  assign tie  = idle & req0 & req1;

  // rr_q holds the last granted input; a tie goes to the other one
  assign win0 = idle & req0 & (~req1 | rr_q);
  assign win1 = idle & req1 & (~req0 | ~rr_q);
  assign sel0 = win0 | (state_q == BUSY0);
  assign sel1 = win1 | (state_q == BUSY1);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b1;
      grant_q <= 2'b00;
      beat_q  <= '0;
      drop0_q <= '0;
      drop1_q <= '0;
      pkt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      drop0_q <= drop0_d;
      drop1_q <= drop1_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (win0) begin
          rr_d = 1'b0;
          if (!eop0) state_d = BUSY0;
        end else if (win1) begin
          rr_d = 1'b1;
          if (!eop1) state_d = BUSY1;
        end
      end
      BUSY0: if (eop0) state_d = IDLE;
      BUSY1: if (eop1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  function automatic logic [CNT_W-1:0] cnt_nxt(
    input logic [CNT_W-1:0] q,
    input logic             inc,
    input logic             clr
  );
    logic [CNT_W-1:0] r;
    r = q;
    if (clr)
      r = '0;
    else if (inc && (q != {CNT_W{1'b1}}))
      r = q + 1'b1;
    return r;
  endfunction

  always_comb begin
    beat_d = '0;
    unique case (1'b1)
      sel0 && in0.valid:
        beat_d = {1'b1, in0.sop, in0.eop, in0.empty, in0.data};
      sel1 && in1.valid:
        beat_d = {1'b1, in1.sop, in1.eop, in1.empty, in1.data};
      default: beat_d = '0;
    endcase

    // grant spans the beats of a multi-beat packet, including its eop
    grant_d[0] = (state_q == BUSY0) | (state_d == BUSY0);
    grant_d[1] = (state_q == BUSY1) | (state_d == BUSY1);

    pkt_inc   = (sel0 & eop0) | (sel1 & eop1);
    err_inc   = ((state_q == BUSY0) & sop0)
              | ((state_q == BUSY1) & sop1);
    drop0_inc = ((state_q == BUSY1) & req0) | (tie & win1);
    drop1_inc = ((state_q == BUSY0) & req1) | (tie & win0);

    drop0_d = cnt_nxt(drop0_q, drop0_inc, clr_cnt);
    drop1_d = cnt_nxt(drop1_q, drop1_inc, clr_cnt);
    pkt_d   = cnt_nxt(pkt_q, pkt_inc, clr_cnt);
    err_d   = cnt_nxt(err_q, err_inc, clr_cnt);
  end

  assign out.valid = beat_q.valid;
  assign out.sop   = beat_q.sop;
  assign out.eop   = beat_q.eop;
  assign out.empty = beat_q.empty;
  assign out.data  = beat_q.data;
  assign grant     = grant_q;
  assign drop_cnt0 = drop0_q;
  assign drop_cnt1 = drop1_q;
  assign pkt_cnt   = pkt_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_pkt_arb.sv
// Directed vector bench for pkt_arb: table of per-cycle stimulus and
// expected registered outputs, plus reset and saturation sequences.
module tb_pkt_arb;

  typedef struct packed {
    logic        valid;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [1:0] en;
    logic       clr;
    beat_t      a;
    beat_t      b;
    beat_t      o;
    logic [1:0] g;
    int         pkt;
    int         d0;
    int         d1;
    int         err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en;
  logic        clr;
  logic [1:0]  grant, grant2;
  logic [15:0] d0c, d1c, pkc, erc;
  logic [1:0]  d0c2, d1c2, pkc2, erc2;

  int nvec = 0;
  int nmis = 0;
  vec_t vq[$];

  pkt_arb_if a_if ();
  pkt_arb_if b_if ();
  pkt_arb_if o_if ();
  pkt_arb_if o2_if ();

  pkt_arb #(.CNT_W(16)) dut (
    .sys_clk(clk), .reset(rst), .en(en), .clr_cnt(clr),
    .in0(a_if), .in1(b_if), .out(o_if), .grant(grant),
    .drop_cnt0(d0c), .drop_cnt1(d1c),
    .pkt_cnt(pkc), .err_cnt(erc)
  );

  pkt_arb #(.CNT_W(2)) dut2 (
    .sys_clk(clk), .reset(rst), .en(en), .clr_cnt(clr),
    .in0(a_if), .in1(b_if), .out(o2_if), .grant(grant2),
    .drop_cnt0(d0c2), .drop_cnt1(d1c2),
    .pkt_cnt(pkc2), .err_cnt(erc2)
  );

  always #5 clk = ~clk;

  function automatic beat_t bt(
    input logic v, input logic s, input logic e,
    input logic [1:0] emp, input logic [31:0] d
  );
    return {v, s, e, emp, d};
  endfunction

  function automatic vec_t mk(
    input logic [1:0] e, input logic c,
    input beat_t a, input beat_t b, input beat_t o,
    input logic [1:0] g,
    input int p, input int x0, input int x1, input int er
  );
    vec_t v;
    v.en = e; v.clr = c; v.a = a; v.b = b; v.o = o;
    v.g = g; v.pkt = p; v.d0 = x0; v.d1 = x1; v.err = er;
    return v;
  endfunction

  task automatic drive(
    input logic [1:0] e, input logic c,
    input beat_t a, input beat_t b
  );
    en = e;
    clr = c;
    {a_if.valid, a_if.sop, a_if.eop, a_if.empty, a_if.data} = a;
    {b_if.valid, b_if.sop, b_if.eop, b_if.empty, b_if.data} = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_row(
    input string nm, input beat_t eo, input logic [1:0] eg,
    input int ep, input int e0, input int e1, input int ee
  );
    beat_t ao;
    ao = {o_if.valid, o_if.sop, o_if.eop, o_if.empty, o_if.data};
    nvec++;
    if (ao !== eo) begin
      nmis++;
      $display("FAIL %s out: got %h expected %h", nm, ao, eo);
    end
    if (grant !== eg) begin
      nmis++;
      $display("FAIL %s grant: got %b expected %b", nm, grant, eg);
    end
    if (pkc !== 16'(ep)) begin
      nmis++;
      $display("FAIL %s pkt_cnt: got %0d expected %0d", nm, pkc, ep);
    end
    if (d0c !== 16'(e0)) begin
      nmis++;
      $display("FAIL %s drop_cnt0: got %0d expected %0d", nm, d0c, e0);
    end
    if (d1c !== 16'(e1)) begin
      nmis++;
      $display("FAIL %s drop_cnt1: got %0d expected %0d", nm, d1c, e1);
    end
    if (erc !== 16'(ee)) begin
      nmis++;
      $display("FAIL %s err_cnt: got %0d expected %0d", nm, erc, ee);
    end
  endtask

  initial begin
    beat_t z;
    z = '0;

    // tie after reset: in0 wins, in1 dropped, non-sop in1 beat discarded
    vq.push_back(mk(3, 0, bt(1,1,0,0,'h10), bt(1,1,0,0,'h20),
                    bt(1,1,0,0,'h10), 1, 0, 0, 1, 0));
    vq.push_back(mk(3, 0, bt(1,0,1,0,'h11), bt(1,0,0,0,'h21),
                    bt(1,0,1,0,'h11), 1, 1, 0, 1, 0));
    vq.push_back(mk(3, 0, z, z, z, 0, 1, 0, 1, 0));
    // second tie: in1 wins
    vq.push_back(mk(3, 0, bt(1,1,0,0,'h30), bt(1,1,0,1,'h40),
                    bt(1,1,0,1,'h40), 2, 1, 1, 1, 0));
    vq.push_back(mk(3, 0, z, bt(1,0,1,3,'h41),
                    bt(1,0,1,3,'h41), 2, 2, 1, 1, 0));
    vq.push_back(mk(3, 0, z, z, z, 0, 2, 1, 1, 0));
    // single packet with a gap, invalid/ignored beats on the side
    vq.push_back(mk(3, 0, bt(1,1,0,0,'h50), bt(0,1,1,0,'hEE),
                    bt(1,1,0,0,'h50), 1, 2, 1, 1, 0));
    vq.push_back(mk(3, 0, bt(1,0,0,0,'h51), bt(1,0,0,2,'h55),
                    bt(1,0,0,0,'h51), 1, 2, 1, 1, 0));
    vq.push_back(mk(3, 0, bt(0,0,1,0,'h99), z,
                    z, 1, 2, 1, 1, 0));
    vq.push_back(mk(3, 0, bt(1,0,1,1,'h52), z,
                    bt(1,0,1,1,'h52), 1, 3, 1, 1, 0));
    vq.push_back(mk(3, 0, z, z, z, 0, 3, 1, 1, 0));
    // collisions while BUSY0, including on the eop cycle
    vq.push_back(mk(3, 0, bt(1,1,0,0,'h60), z,
                    bt(1,1,0,0,'h60), 1, 3, 1, 1, 0));
    vq.push_back(mk(3, 0, bt(1,0,0,0,'h61), bt(1,1,0,0,'h70),
                    bt(1,0,0,0,'h61), 1, 3, 1, 2, 0));
    vq.push_back(mk(3, 0, bt(1,0,1,0,'h62), bt(1,1,1,0,'h71),
                    bt(1,0,1,0,'h62), 1, 4, 1, 3, 0));
    vq.push_back(mk(3, 0, z, z, z, 0, 4, 1, 3, 0));
    // back-to-back single-beat packets on in1
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(3, 0, z, bt(1,1,1,0,32'h80 + i),
                      bt(1,1,1,0,32'h80 + i), 0, 5 + i, 1, 3, 0));
    vq.push_back(mk(3, 0, z, z, z, 0, 8, 1, 3, 0));
    // double sop inside packet, then disabled input
    vq.push_back(mk(3, 0, bt(1,1,0,0,'h90), z,
                    bt(1,1,0,0,'h90), 1, 8, 1, 3, 0));
    vq.push_back(mk(3, 0, bt(1,1,0,0,'h91), z,
                    bt(1,1,0,0,'h91), 1, 8, 1, 3, 1));
    vq.push_back(mk(3, 0, bt(1,0,1,0,'h92), z,
                    bt(1,0,1,0,'h92), 1, 9, 1, 3, 1));
    vq.push_back(mk(2, 0, bt(1,1,1,0,'h93), z,
                    z, 0, 9, 1, 3, 1));
    // en dropped mid-packet does not truncate; disabled sop not a drop
    vq.push_back(mk(1, 0, bt(1,1,0,0,'hA0), z,
                    bt(1,1,0,0,'hA0), 1, 9, 1, 3, 1));
    vq.push_back(mk(0, 0, bt(1,0,0,0,'hA1), bt(1,1,0,0,'hB1),
                    bt(1,0,0,0,'hA1), 1, 9, 1, 3, 1));
    vq.push_back(mk(0, 0, bt(1,0,1,2,'hA2), z,
                    bt(1,0,1,2,'hA2), 1, 10, 1, 3, 1));
    vq.push_back(mk(0, 0, z, z, z, 0, 10, 1, 3, 1));
    // sop&eop inside a packet ends it and counts an error
    vq.push_back(mk(3, 0, bt(1,1,0,0,'hD0), z,
                    bt(1,1,0,0,'hD0), 1, 10, 1, 3, 1));
    vq.push_back(mk(3, 0, bt(1,1,1,0,'hD1), z,
                    bt(1,1,1,0,'hD1), 1, 11, 1, 3, 2));
    vq.push_back(mk(3, 0, z, z, z, 0, 11, 1, 3, 2));
    // clear wins over a same-cycle increment
    vq.push_back(mk(3, 1, bt(1,1,1,0,'hC0), z,
                    bt(1,1,1,0,'hC0), 0, 0, 0, 0, 0));
    vq.push_back(mk(3, 0, z, z, z, 0, 0, 0, 0, 0));

    rst = 1'b1;
    drive(3, 1, bt(1,1,0,0,'h77), bt(1,1,0,0,'h78));
    step();
    step();
    check_row("reset", z, 0, 0, 0, 0, 0);
    drive(3, 0, z, z);
    step();
    rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].en, vq[i].clr, vq[i].a, vq[i].b);
      step();
      check_row($sformatf("row%0d", i), vq[i].o, vq[i].g,
                vq[i].pkt, vq[i].d0, vq[i].d1, vq[i].err);
    end

    // reset in the middle of a BUSY1 packet
    drive(3, 0, z, bt(1,1,0,0,'hE0));
    step();
    check_row("mid_a", bt(1,1,0,0,'hE0), 2, 0, 0, 0, 0);
    drive(3, 0, bt(1,1,0,0,'hF0), bt(1,0,0,0,'hE1));
    step();
    check_row("mid_b", bt(1,0,0,0,'hE1), 2, 0, 1, 0, 0);
    rst = 1'b1;
    drive(3, 0, z, bt(1,0,0,0,'hE2));
    step();
    check_row("mid_rst", z, 0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(3, 0, z, bt(1,0,1,0,'hE3));
    step();
    check_row("mid_after", z, 0, 0, 0, 0, 0);

    // saturation on the narrow-counter instance
    for (int i = 0; i < 5; i++) begin
      drive(3, 0, bt(1,1,1,0,32'h100 + i), z);
      step();
      chk($sformatf("sat_pkt%0d", i), int'(pkc2), (i < 3) ? i + 1 : 3);
      chk($sformatf("wide_pkt%0d", i), int'(pkc), i + 1);
    end
    drive(3, 1, z, z);
    step();
    chk("sat_clr", int'(pkc2), 0);
    chk("wide_clr", int'(pkc), 0);
    drive(3, 0, z, z);
    step();
    chk("sat_hold", int'(pkc2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
